// File: rtl/mod_calc_pkg.sv
// mod_calc_pkg: shared definitions for the sequential modular reducer.
//   state_e   : controller states (IDLE / RUN / DONE)
//   top_chunk : extracts the most significant chunk_w bits of an 8-bit window
package mod_calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The caller supplies the top 8 bits of the operand register; the chunk
  // to process next is the leading chunk_w (1..8) bits of that window.
  function automatic logic [7:0] top_chunk(input logic [7:0]  top_bits,
                                           input int unsigned chunk_w);
    return top_bits >> (8 - chunk_w);
  endfunction

endpackage

// File: rtl/mod_step.sv
// mod_step: one Horner step of the reduction, purely combinational.
//   acc_i   [RES_W]  current residue, must be < MOD
//   chunk_i [CHUNK]  next operand chunk
//   res_o   [RES_W]  (acc_i * 2^CHUNK + chunk_i) mod MOD
// Implemented as a restoring-division chain of CHUNK+1 conditional
// subtractions of MOD << k, so no multiplier or divider is inferred.
module mod_step #(
  parameter int MOD   = 113,
  parameter int CHUNK = 6,
  parameter int RES_W = $clog2(MOD)
) (
  input  logic [RES_W-1:0] acc_i,
  input  logic [CHUNK-1:0] chunk_i,
  output logic [RES_W-1:0] res_o
);

  // One spare bit so MOD itself (which may equal 2^RES_W) and MOD << CHUNK
  // are representable.
  localparam int WW = RES_W + CHUNK + 1;
  localparam logic [WW-1:0] MOD_W = WW'(MOD);

  logic [WW-1:0] v;

  always_comb begin
    v = {1'b0, acc_i, chunk_i};
    // acc_i < MOD bounds v below MOD << CHUNK, so after stage k the value
    // is below MOD << k; after stage 0 it is the residue.
    for (int k = CHUNK; k >= 0; k--) begin
      if (v >= (MOD_W << k)) begin
        v = v - (MOD_W << k);
      end
    end
    res_o = v[RES_W-1:0];
  end

endmodule

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: computes in_data mod MOD, CHUNK bits per cycle, MSB first.
//   clk, rst_n            clock (rising) / async active-low reset
//   in_valid, in_ready    operand handshake, in_data [IN_W] unsigned operand
//   abort                 synchronous cancel while RUN or DONE
//   out_valid, out_ready  result handshake, out_res [RES_W]
//   busy                  high while RUN
//   dbg_state             current controller state (state_e encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE (and never before the first edge
// after reset release); out_valid is high only in DONE and out_res is stable
// until the result is taken or aborted. Abort wins over out_ready.
module mod_reduce_seq
  import mod_calc_pkg::*;
#(
  parameter int MOD   = 113,
  parameter int IN_W  = 400,
  parameter int CHUNK = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(MOD)-1:0]   out_res,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int RES_W = $clog2(MOD);
  localparam int NCH   = (IN_W + CHUNK - 1) / CHUNK;
  localparam int CNT_W = $clog2(NCH + 1);
  localparam int PW    = NCH * CHUNK;

  state_e           state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    op_q, op_d;
  logic             rdy_q;

  logic [7:0]       top8;
  logic [CHUNK-1:0] cur_chunk;
  logic [RES_W-1:0] step_res;

  // The operand register shifts left by CHUNK every RUN cycle, so the chunk
  // indexed by cnt_q is always sitting in its top bits.
  assign top8      = 8'({op_q, 8'd0} >> PW);
  assign cur_chunk = CHUNK'(top_chunk(top8, CHUNK));

  mod_step #(
    .MOD   (MOD),
    .CHUNK (CHUNK),
    .RES_W (RES_W)
  ) u_step (
    .acc_i   (acc_q),
    .chunk_i (cur_chunk),
    .res_o   (step_res)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = PW'(in_data);
          acc_d   = '0;
          cnt_d   = CNT_W'(NCH - 1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_res;
          op_d  = op_q << CHUNK;
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (abort || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rdy_q   <= 1'b1;
    end
  end

  // rdy_q keeps in_ready low while reset is held and until the first edge.
  assign in_ready  = rdy_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign out_res   = acc_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mod_reduce_seq.md
MOD_REDUCE_SEQ -- requirements
Module: mod_reduce_seq

Interface
REQ-001 SHALL have parameter MOD, default 113, the modulus (prime or composite, >= 2).
REQ-002 SHALL have parameter IN_W, default 400, the operand width in bits.
REQ-003 SHALL have parameter CHUNK, default 6, the bits consumed per cycle (1..8).
REQ-004 SHALL derive localparams RES_W = $clog2(MOD), NCH = ceil(IN_W/CHUNK), CNT_W = $clog2(NCH+1).
REQ-005 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port in_valid  input  1  operand offered.
REQ-008 SHALL have port in_ready  output  1  block can accept an operand.
REQ-009 SHALL have port in_data  input  IN_W  operand, unsigned.
REQ-010 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port out_res  output  RES_W  in_data mod MOD.
REQ-014 SHALL have port busy  output  1  high in RUN state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-017 On IDLE with in_valid = 1: latch in_data zero-extended to NCH*CHUNK bits, acc <= 0, cnt <= NCH-1, go to RUN.
REQ-018 In RUN, each cycle: acc <= (acc * 2^CHUNK + chunk[cnt]) mod MOD (Horner order, MSB chunk first), cnt <= cnt-1.
REQ-019 The RUN cycle that processes chunk 0 SHALL transition to DONE; out_valid SHALL rise exactly NCH cycles after the accepting edge (67 at defaults).
REQ-020 acc SHALL stay < MOD after every step; out_res SHALL equal acc in DONE and hold its value stable while out_ready = 0.
REQ-021 On DONE with out_ready = 1: go to IDLE; a new operand SHALL NOT be accepted in that same cycle (in_ready low in DONE).
REQ-022 abort = 1 in RUN or DONE SHALL force IDLE on the next edge with no out_valid pulse; abort in IDLE SHALL have no effect; abort SHALL take priority over out_ready.
REQ-023 Operand value 0 and values >= MOD, including all-ones, SHALL reduce correctly; no overflow of acc*2^CHUNK+chunk, the intermediate held at RES_W+CHUNK bits.
REQ-024 in_data changes after acceptance SHALL not affect the result.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, acc 0, cnt 0, and the operand register 0.
REQ-026 While reset is asserted: in_ready 0, out_valid 0, busy 0, out_res 0; in_ready SHALL go to 1 on the first edge after release.
REQ-027 Reset mid-RUN or mid-DONE SHALL discard the operation silently.

Structure
REQ-028 SHALL place the FSM state enum and a function computing CHUNK-bit chunk extraction in package mod_calc_pkg.
REQ-029 SHALL instantiate one combinational sub-module mod_step (inputs acc[RES_W], chunk[CHUNK]; output (acc*2^CHUNK+chunk) mod MOD), built from a MOD-parameterised constant table or a conditional-subtract chain of CHUNK+1 stages.
REQ-030 SHALL contain no multiplier or divider inferred on the IN_W-wide operand.

Verification
REQ-031 Bench SHALL drive in_data=0, then 112, then 114 -> out_res 0, 112, 1, each NCH cycles after accept.
REQ-032 Bench SHALL drive in_data=113*1000+5 with out_ready held low 10 cycles -> out_res 5 stable for the whole stall, then IDLE one cycle after out_ready.
REQ-033 Bench SHALL assert abort at RUN cycle 20 -> IDLE next edge, no out_valid, following operand 226 -> 0.
REQ-034 Bench SHALL pulse rst_n low at RUN cycle 30 -> outputs 0 asynchronously, in_ready 1 after release, next operand 7 -> 7.
REQ-035 Bench SHALL run 1000 random IN_W-bit operands, including all-ones, for (MOD,IN_W,CHUNK) in {(113,400,6),(7,16,1),(251,64,8)} -> out_res matches a golden big-integer model.
